// File: rtl/issue_dispatch_sb.sv
// Issue stage: register-status scoreboard plus lowest-free-unit allocator for N_ALU/N_MEM units.
// Operands leave as a value or as the producer tag; the ROB writeback bus frees units and commits values.
module issue_dispatch_sb #(
  parameter int N_ALU = 3,
  parameter int N_MEM = 1,
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int SEQ_W = 4,
  parameter int TAG_W = $clog2(N_ALU + N_MEM + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     id_valid,
  output logic                     id_ready,
  input  logic [1:0]               id_kind,
  input  logic [$clog2(NREG)-1:0]  id_rs1,
  input  logic                     id_use_rs1,
  input  logic [$clog2(NREG)-1:0]  id_rs2,
  input  logic                     id_use_rs2,
  input  logic [$clog2(NREG)-1:0]  id_rd,
  input  logic                     id_wr_rd,
  input  logic                     wb_valid,
  input  logic [TAG_W-1:0]         wb_tag,
  input  logic [$clog2(NREG)-1:0]  wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  output logic                     iss_valid,
  output logic [TAG_W-1:0]         iss_tag,
  output logic [SEQ_W-1:0]         iss_seq,
  output logic [TAG_W-1:0]         iss_q1,
  output logic [TAG_W-1:0]         iss_q2,
  output logic [XLEN-1:0]          iss_v1,
  output logic [XLEN-1:0]          iss_v2,
  output logic [N_ALU+N_MEM-1:0]   busy_units
);

  localparam int NU = N_ALU + N_MEM;
  localparam int RW = $clog2(NREG);

  logic [NU-1:0]    busy, busy_nxt, alloc_mask;
  logic [TAG_W-1:0] stat [NREG];
  logic [XLEN-1:0]  regs [NREG];
  logic [SEQ_W-1:0] seq;
  logic             is_op, alloc_found, fire, wb_ok, wb_commit;
  logic [TAG_W-1:0] alloc_tag, q1_nxt, q2_nxt;
  logic [XLEN-1:0]  v1_nxt, v2_nxt;

  function automatic logic [TAG_W+XLEN-1:0] operand(
    input logic             use_rs,
    input logic [RW-1:0]    rs,
    input logic [TAG_W-1:0] st,
    input logic [XLEN-1:0]  val,
    input logic             hit_ok,
    input logic [TAG_W-1:0] hit_tag,
    input logic [XLEN-1:0]  hit_data
  );
    if (!use_rs || rs == '0)            operand = '0;
    else if (st == '0)                  operand = {{TAG_W{1'b0}}, val};
    else if (hit_ok && hit_tag == st)   operand = {{TAG_W{1'b0}}, hit_data};
    else                                operand = {st, {XLEN{1'b0}}};
  endfunction

  assign is_op     = (id_kind == 2'd1) || (id_kind == 2'd2);
  assign id_ready  = id_valid && !flush && !rst && (!is_op || alloc_found);
  assign fire      = id_ready && is_op;
  assign wb_ok     = wb_valid && (wb_tag != '0) && (wb_tag <= TAG_W'(NU));
  assign wb_commit = wb_ok && (wb_rd != '0) && (stat[wb_rd] == wb_tag);
  assign busy_units = busy;

  always_comb begin
    alloc_found = 1'b0;
    alloc_tag   = '0;
    alloc_mask  = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (!alloc_found && !busy[i] &&
          ((id_kind == 2'd1 && i <  unsigned'(N_ALU)) ||
           (id_kind == 2'd2 && i >= unsigned'(N_ALU)))) begin
        alloc_found   = 1'b1;
        alloc_tag     = TAG_W'(i + 1);
        alloc_mask[i] = 1'b1;
      end
    end
  end

  // Free before allocate, so a unit released this cycle cannot be re-granted until the next one.
  always_comb begin
    busy_nxt = busy;
    for (int unsigned i = 0; i < NU; i++) begin
      if (wb_ok && wb_tag == TAG_W'(i + 1)) busy_nxt[i] = 1'b0;
    end
    if (flush) busy_nxt = '0;
    if (fire)  busy_nxt = busy_nxt | alloc_mask;
  end

  assign {q1_nxt, v1_nxt} = operand(id_use_rs1, id_rs1, stat[id_rs1], regs[id_rs1], wb_ok, wb_tag, wb_data);
  assign {q2_nxt, v2_nxt} = operand(id_use_rs2, id_rs2, stat[id_rs2], regs[id_rs2], wb_ok, wb_tag, wb_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= '0;
      seq       <= '0;
      iss_valid <= 1'b0;
      iss_tag   <= '0;
      iss_seq   <= '0;
      iss_q1    <= '0;
      iss_q2    <= '0;
      iss_v1    <= '0;
      iss_v2    <= '0;
      for (int unsigned r = 0; r < NREG; r++) begin
        stat[r] <= '0;
        regs[r] <= '0;
      end
    end else begin
      busy      <= busy_nxt;
      iss_valid <= fire;
      if (wb_commit) begin
        regs[wb_rd] <= wb_data;
        stat[wb_rd] <= '0;
      end
      if (flush) begin
        for (int unsigned r = 0; r < NREG; r++) stat[r] <= '0;
      end
      // Rename is written last so a same-cycle rename of wb_rd overrides the commit's clear.
      if (fire) begin
        iss_tag <= alloc_tag;
        iss_seq <= seq;
        seq     <= seq + 1'b1;
        iss_q1  <= q1_nxt;
        iss_v1  <= v1_nxt;
        iss_q2  <= q2_nxt;
        iss_v2  <= v2_nxt;
        if (id_wr_rd && id_rd != '0) stat[id_rd] <= alloc_tag;
      end
    end
  end

endmodule

// File: tb/tb_issue_dispatch_sb.sv
// Directed bench for issue_dispatch_sb at default parameters (tags 1..3 ALU, tag 4 MEM).
module tb_issue_dispatch_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [1:0]  id_kind = 2'd0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0, wb_rd = '0;
  logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_wr_rd = 1'b0;
  logic        wb_valid = 1'b0;
  logic [2:0]  wb_tag = '0;
  logic [31:0] wb_data = '0;
  logic        iss_valid;
  logic [2:0]  iss_tag, iss_q1, iss_q2;
  logic [3:0]  iss_seq;
  logic [31:0] iss_v1, iss_v2;
  logic [3:0]  busy_units;

  int checks = 0;
  int errors = 0;

  issue_dispatch_sb #(.N_ALU(3), .N_MEM(1), .XLEN(32), .NREG(32), .SEQ_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_kind(id_kind), .id_rs1(id_rs1), .id_use_rs1(id_use_rs1), .id_rs2(id_rs2),
    .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wr_rd(id_wr_rd), .wb_valid(wb_valid),
    .wb_tag(wb_tag), .wb_rd(wb_rd), .wb_data(wb_data), .iss_valid(iss_valid),
    .iss_tag(iss_tag), .iss_seq(iss_seq), .iss_q1(iss_q1), .iss_q2(iss_q2),
    .iss_v1(iss_v1), .iss_v2(iss_v2), .busy_units(busy_units)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_kind = 2'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_wr_rd = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_rd = '0; wb_data = '0; flush = 1'b0;
  endtask

  task automatic set_op(input logic [1:0] k, input logic u1, input logic [4:0] r1,
                        input logic u2, input logic [4:0] r2, input logic w, input logic [4:0] rd);
    id_valid = 1'b1; id_kind = k; id_use_rs1 = u1; id_rs1 = r1;
    id_use_rs2 = u2; id_rs2 = r2; id_wr_rd = w; id_rd = rd;
  endtask

  task automatic set_wb(input logic [2:0] t, input logic [4:0] rd, input logic [31:0] d);
    wb_valid = 1'b1; wb_tag = t; wb_rd = rd; wb_data = d;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    set_op(2'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3);
    tick(); tick();
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", id_ready); end
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", iss_valid); end
    checks++; if (busy_units !== 4'b0000) begin errors++; $display("FAIL reset_busy: got %b exp 0000", busy_units); end
    checks++; if (iss_seq !== 4'd0 || iss_tag !== 3'd0) begin errors++; $display("FAIL reset_iss: seq %0d tag %0d exp 0 0", iss_seq, iss_tag); end
    idle();
    rst = 1'b0;
  endtask

  task automatic test_alu_basic();
    do_reset();
    set_op(2'd1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3);
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b exp 1", id_ready); end
    tick();
    idle();
    checks++; if (iss_valid !== 1'b1 || iss_tag !== 3'd1 || iss_seq !== 4'd0) begin errors++;
      $display("FAIL basic_issue: valid %b tag %0d seq %0d exp 1 1 0", iss_valid, iss_tag, iss_seq); end
    checks++; if (iss_q1 !== 3'd0 || iss_q2 !== 3'd0 || iss_v1 !== 32'd0 || iss_v2 !== 32'd0) begin errors++;
      $display("FAIL basic_opnd: q1 %0d q2 %0d v1 %h v2 %h exp all 0", iss_q1, iss_q2, iss_v1, iss_v2); end
    checks++; if (busy_units !== 4'b0001) begin errors++; $display("FAIL basic_busy: got %b exp 0001", busy_units); end
    tick();
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL basic_onecycle: got %b exp 0", iss_valid); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_tag [3];
    exp_tag[0] = 3'd1; exp_tag[1] = 3'd2; exp_tag[2] = 3'd3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_op(2'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'(10 + i));
      tick();
      checks++; if (iss_valid !== 1'b1 || iss_tag !== exp_tag[i] || iss_seq !== 4'(i)) begin errors++;
        $display("FAIL b2b_issue%0d: valid %b tag %0d seq %0d exp 1 %0d %0d", i, iss_valid, iss_tag, iss_seq, exp_tag[i], i); end
    end
    set_op(2'd1, 1'b1, 5'd11, 1'b0, 5'd0, 1'b1, 5'd13);
    set_wb(3'd5, 5'd11, 32'hBAD);
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b exp 0", id_ready); end
    tick();
    checks++; if (iss_valid !== 1'b0 || busy_units !== 4'b0111) begin errors++;
      $display("FAIL b2b_badtag: valid %b busy %b exp 0 0111", iss_valid, busy_units); end
    set_wb(3'd2, 5'd11, 32'h22);
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL b2b_free_same_cycle: got %b exp 0", id_ready); end
    tick();
    wb_valid = 1'b0;
    checks++; if (busy_units !== 4'b0101 || iss_valid !== 1'b0) begin errors++;
      $display("FAIL b2b_freed: busy %b valid %b exp 0101 0", busy_units, iss_valid); end
    tick();
    idle();
    checks++; if (iss_valid !== 1'b1 || iss_tag !== 3'd2 || iss_seq !== 4'd3) begin errors++;
      $display("FAIL b2b_fourth: valid %b tag %0d seq %0d exp 1 2 3", iss_valid, iss_tag, iss_seq); end
    checks++; if (iss_q1 !== 3'd0 || iss_v1 !== 32'h22) begin errors++;
      $display("FAIL b2b_committed: q1 %0d v1 %h exp 0 00000022", iss_q1, iss_v1); end
  endtask

  task automatic test_dependency();
    do_reset();
    set_op(2'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5);
    tick();
    set_op(2'd1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd6);
    tick();
    checks++; if (iss_tag !== 3'd2 || iss_q1 !== 3'd1 || iss_v1 !== 32'd0) begin errors++;
      $display("FAIL dep_wait: tag %0d q1 %0d v1 %h exp 2 1 0", iss_tag, iss_q1, iss_v1); end
    set_op(2'd1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd7);
    set_wb(3'd1, 5'd5, 32'hDEAD);
    tick();
    idle();
    checks++; if (iss_tag !== 3'd3 || iss_q1 !== 3'd0 || iss_v1 !== 32'hDEAD) begin errors++;
      $display("FAIL dep_bypass: tag %0d q1 %0d v1 %h exp 3 0 0000dead", iss_tag, iss_q1, iss_v1); end
    checks++; if (busy_units !== 4'b0110) begin errors++; $display("FAIL dep_busy: got %b exp 0110", busy_units); end
    set_op(2'd1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    idle();
    checks++; if (iss_tag !== 3'd1 || iss_q1 !== 3'd0 || iss_v1 !== 32'hDEAD) begin errors++;
      $display("FAIL dep_reg: tag %0d q1 %0d v1 %h exp 1 0 0000dead", iss_tag, iss_q1, iss_v1); end
  endtask

  task automatic test_rename_wb();
    do_reset();
    set_op(2'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5);
    tick();
    set_op(2'd1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5);
    set_wb(3'd1, 5'd5, 32'h1234);
    tick();
    wb_valid = 1'b0;
    checks++; if (iss_tag !== 3'd2 || iss_q1 !== 3'd0 || iss_v1 !== 32'h1234) begin errors++;
      $display("FAIL rename_bypass: tag %0d q1 %0d v1 %h exp 2 0 00001234", iss_tag, iss_q1, iss_v1); end
    set_op(2'd1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0);
    tick();
    idle();
    checks++; if (iss_tag !== 3'd1 || iss_q1 !== 3'd2 || iss_q2 !== 3'd2 || iss_v1 !== 32'd0) begin errors++;
      $display("FAIL rename_stat: tag %0d q1 %0d q2 %0d v1 %h exp 1 2 2 0", iss_tag, iss_q1, iss_q2, iss_v1); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_op(2'd1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    idle();
    checks++; if (iss_tag !== 3'd1 || iss_q1 !== 3'd0 || iss_v1 !== 32'h1234) begin errors++;
      $display("FAIL rename_reg: tag %0d q1 %0d v1 %h exp 1 0 00001234", iss_tag, iss_q1, iss_v1); end
  endtask

  task automatic test_mem_flush();
    do_reset();
    set_op(2'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8);
    tick();
    checks++; if (iss_tag !== 3'd4 || busy_units !== 4'b1000) begin errors++;
      $display("FAIL mem_issue: tag %0d busy %b exp 4 1000", iss_tag, busy_units); end
    set_op(2'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9);
    tick();
    set_op(2'd2, 1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd20);
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL mem_stall_ready: got %b exp 0", id_ready); end
    tick();
    flush = 1'b1;
    set_wb(3'd1, 5'd9, 32'h99);
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b exp 0", id_ready); end
    tick();
    flush = 1'b0; wb_valid = 1'b0;
    checks++; if (busy_units !== 4'b0000 || iss_valid !== 1'b0) begin errors++;
      $display("FAIL flush_clear: busy %b valid %b exp 0000 0", busy_units, iss_valid); end
    tick();
    checks++; if (iss_valid !== 1'b1 || iss_tag !== 3'd4 || iss_seq !== 4'd2 || iss_q1 !== 3'd0 || iss_v1 !== 32'd0) begin errors++;
      $display("FAIL flush_mem: valid %b tag %0d seq %0d q1 %0d v1 %h exp 1 4 2 0 0", iss_valid, iss_tag, iss_seq, iss_q1, iss_v1); end
    set_op(2'd1, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0);
    tick();
    idle();
    checks++; if (iss_tag !== 3'd1 || iss_q2 !== 3'd0 || iss_v2 !== 32'h99) begin errors++;
      $display("FAIL flush_wb_commit: tag %0d q2 %0d v2 %h exp 1 0 00000099", iss_tag, iss_q2, iss_v2); end
  endtask

  task automatic test_nop();
    do_reset();
    for (int k = 0; k < 4; k += 3) begin
      set_op(2'(k), 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4);
      #1;
      checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL nop_ready%0d: got %b exp 1", k, id_ready); end
      tick();
      checks++; if (iss_valid !== 1'b0 || busy_units !== 4'b0000) begin errors++;
        $display("FAIL nop_noissue%0d: valid %b busy %b exp 0 0000", k, iss_valid, busy_units); end
    end
    set_op(2'd1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    idle();
    checks++; if (iss_seq !== 4'd0 || iss_q1 !== 3'd0) begin errors++;
      $display("FAIL nop_seq: seq %0d q1 %0d exp 0 0", iss_seq, iss_q1); end
  endtask

  task automatic test_seq_wrap_x0();
    logic [2:0] prev;
    do_reset();
    prev = '0;
    for (int i = 0; i < 17; i++) begin
      set_op(2'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0);
      if (i > 0) set_wb(prev, 5'd0, 32'h5A5A);
      tick();
      prev = iss_tag;
      checks++; if (iss_valid !== 1'b1 || iss_seq !== 4'(i % 16)) begin errors++;
        $display("FAIL seq_%0d: valid %b seq %0d exp 1 %0d", i, iss_valid, iss_seq, i % 16); end
    end
    idle();
    set_op(2'd1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0);
    set_wb(prev, 5'd0, 32'h5A5A);
    tick();
    idle();
    checks++; if (iss_q1 !== 3'd0 || iss_v1 !== 32'd0 || iss_q2 !== 3'd0 || iss_v2 !== 32'd0) begin errors++;
      $display("FAIL x0_read: q1 %0d v1 %h q2 %0d v2 %h exp 0 0 0 0", iss_q1, iss_v1, iss_q2, iss_v2); end
  endtask

  task automatic test_rst_midop();
    set_op(2'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
    tick();
    rst = 1'b1;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b exp 0", id_ready); end
    tick();
    rst = 1'b0;
    idle();
    checks++; if (busy_units !== 4'b0000 || iss_valid !== 1'b0 || iss_seq !== 4'd0) begin errors++;
      $display("FAIL rst_mid_state: busy %b valid %b seq %0d exp 0000 0 0", busy_units, iss_valid, iss_seq); end
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_back_to_back();
    test_dependency();
    test_rename_wb();
    test_mem_flush();
    test_nop();
    test_seq_wrap_x0();
    test_rst_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
